// File: rtl/sorted_reader.sv
// Captures a 4-element vector on load, then streams it out one element per
// valid/ready beat (s0 first), flagging any captured vector that is not non-decreasing.
module sorted_reader #(
  parameter int unsigned DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DIGIT-1:0] s0,
  input  logic [DIGIT-1:0] s1,
  input  logic [DIGIT-1:0] s2,
  input  logic [DIGIT-1:0] s3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DIGIT-1:0] out_data,
  output logic [1:0]       out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             order_err
);

  typedef enum logic [2:0] {
    StIdle   = 3'b001,
    StSend   = 3'b010,
    StFinish = 3'b100
  } state_e;

  state_e           state_q;
  logic [DIGIT-1:0] buf_q [4];
  logic [1:0]       idx_q;
  logic             err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      buf_q[2] <= '0;
      buf_q[3] <= '0;
      idx_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (load) begin
            buf_q[0] <= s0;
            buf_q[1] <= s1;
            buf_q[2] <= s2;
            buf_q[3] <= s3;
            idx_q    <= 2'd0;
            err_q    <= !((s0 <= s1) && (s1 <= s2) && (s2 <= s3));
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (out_ready) begin
            if (idx_q == 2'd3) begin
              state_q <= StFinish;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        StFinish: state_q <= StIdle;
        // Any non-one-hot encoding recovers to idle.
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == StSend);
    out_data  = out_valid ? buf_q[idx_q] : '0;
    out_index = out_valid ? idx_q : 2'd0;
    out_last  = out_valid && (idx_q == 2'd3);
    busy      = (state_q == StSend) || (state_q == StFinish);
    done      = (state_q == StFinish);
    order_err = err_q;
  end

endmodule

// File: tb/tb_sorted_reader.sv
// Scoreboard bench for sorted_reader: a 4-bit and an 8-bit instance share clock and reset.
module tb_sorted_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, ready;
  logic [3:0] s0, s1, s2, s3;
  logic       out_valid, out_last, busy, done, order_err;
  logic [3:0] out_data;
  logic [1:0] out_index;

  logic       load_w, ready_w;
  logic [7:0] w0, w1, w2, w3;
  logic       out_valid_w, out_last_w, busy_w, done_w, order_err_w;
  logic [7:0] out_data_w;
  logic [1:0] out_index_w;

  int total = 0;
  int bad   = 0;
  logic [6:0]  q4 [$];
  logic [10:0] q8 [$];

  always #5 clk = ~clk;

  sorted_reader #(.DIGIT(4)) dut (
    .clock(clk), .reset(rst_n), .load(load), .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .out_ready(ready), .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .done(done), .order_err(order_err)
  );

  sorted_reader #(.DIGIT(8)) dut_w (
    .clock(clk), .reset(rst_n), .load(load_w), .s0(w0), .s1(w1), .s2(w2), .s3(w3),
    .out_ready(ready_w), .out_valid(out_valid_w), .out_data(out_data_w),
    .out_index(out_index_w), .out_last(out_last_w), .busy(busy_w), .done(done_w),
    .order_err(order_err_w)
  );

  // Beats are popped where they transfer: valid && ready seen between edges.
  always @(negedge clk) begin
    if (rst_n && out_valid && ready) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL beat4: unexpected beat data=%0d idx=%0d", out_data, out_index);
      end else begin
        logic [6:0] e;
        e = q4.pop_front();
        if ({out_data, out_index, out_last} !== e) begin
          bad++;
          $display("FAIL beat4: got data=%0d idx=%0d last=%0b want data=%0d idx=%0d last=%0b",
                   out_data, out_index, out_last, e[6:3], e[2:1], e[0]);
        end
      end
    end
    if (rst_n && out_valid_w && ready_w) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL beat8: unexpected beat data=%0d idx=%0d", out_data_w, out_index_w);
      end else begin
        logic [10:0] e;
        e = q8.pop_front();
        if ({out_data_w, out_index_w, out_last_w} !== e) begin
          bad++;
          $display("FAIL beat8: got data=%0d idx=%0d last=%0b want data=%0d idx=%0d last=%0b",
                   out_data_w, out_index_w, out_last_w, e[10:3], e[2:1], e[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [3:0] a, b, c, d);
    q4.push_back({a, 2'd0, 1'b0});
    q4.push_back({b, 2'd1, 1'b0});
    q4.push_back({c, 2'd2, 1'b0});
    q4.push_back({d, 2'd3, 1'b1});
  endtask

  task automatic drive4(input logic [3:0] a, b, c, d);
    s0 = a; s1 = b; s2 = c; s3 = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; ready = 1'b1; drive4(4'd0, 4'd0, 4'd0, 4'd0);
    load_w = 1'b0; ready_w = 1'b1; w0 = 0; w1 = 0; w2 = 0; w3 = 0;
    step(); step();
    total++;
    if ({out_valid, out_data, out_index, out_last, busy, done, order_err} !== 11'd0) begin
      bad++;
      $display("FAIL reset: outputs=%b want all zero",
               {out_valid, out_data, out_index, out_last, busy, done, order_err});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive4(4'd1, 4'd3, 4'd3, 4'd9); load = 1'b1; ready = 1'b1;
    push4(4'd1, 4'd3, 4'd3, 4'd9);
    step(); load = 1'b0;
    total++;
    if ({out_valid, busy, order_err} !== 3'b110) begin
      bad++; $display("FAIL basic_start: valid/busy/err=%b want 110", {out_valid, busy, order_err});
    end
    repeat (4) step();
    total++;
    if ({done, out_valid, busy} !== 3'b101) begin
      bad++; $display("FAIL basic_done: done/valid/busy=%b want 101", {done, out_valid, busy});
    end
    step();
    total++;
    if ({done, busy, order_err} !== 3'b000) begin
      bad++; $display("FAIL basic_idle: done/busy/err=%b want 000", {done, busy, order_err});
    end
    total++;
    if (q4.size() != 0) begin
      bad++; $display("FAIL basic_drain: %0d beats left want 0", q4.size());
    end
  endtask

  task automatic test_backpressure();
    drive4(4'd2, 4'd4, 4'd6, 4'd8); load = 1'b1; ready = 1'b1;
    push4(4'd2, 4'd4, 4'd6, 4'd8);
    step(); load = 1'b0;
    step(); ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({out_valid, out_data, out_index} !== {1'b1, 4'd4, 2'd1}) begin
        bad++;
        $display("FAIL hold: valid=%0b data=%0d idx=%0d want 1 4 1", out_valid, out_data, out_index);
      end
    end
    ready = 1'b1;
    repeat (4) step();
    total++;
    if (q4.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_drain: left=%0d busy=%0b want 0 0", q4.size(), busy);
    end
  endtask

  task automatic test_order();
    drive4(4'd5, 4'd2, 4'd7, 4'd7); load = 1'b1; ready = 1'b1;
    push4(4'd5, 4'd2, 4'd7, 4'd7);
    step(); load = 1'b0;
    total++;
    if (order_err !== 1'b1) begin
      bad++; $display("FAIL err_set: order_err=%0b want 1", order_err);
    end
    repeat (5) step();
    total++;
    if ({order_err, busy} !== 2'b10) begin
      bad++; $display("FAIL err_sticky: err/busy=%b want 10", {order_err, busy});
    end
    drive4(4'd0, 4'd0, 4'd0, 4'd0); load = 1'b1;
    push4(4'd0, 4'd0, 4'd0, 4'd0);
    step(); load = 1'b0;
    total++;
    if (order_err !== 1'b0) begin
      bad++; $display("FAIL err_clear: order_err=%0b want 0", order_err);
    end
    repeat (5) step();
    total++;
    if (q4.size() != 0) begin
      bad++; $display("FAIL order_drain: %0d beats left want 0", q4.size());
    end
  endtask

  task automatic test_load_held();
    drive4(4'd10, 4'd11, 4'd12, 4'd13); load = 1'b1; ready = 1'b1;
    push4(4'd10, 4'd11, 4'd12, 4'd13);
    step();
    for (int i = 0; i < 4; i++) begin
      drive4(4'($urandom_range(0, 15)), 4'd1, 4'd0, 4'd15);
      step();
    end
    drive4(4'd14, 4'd14, 4'd14, 4'd14);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL held_done: done=%0b want 1", done);
    end
    step();
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL held_idle: valid/busy=%b want 00", {out_valid, busy});
    end
    drive4(4'd6, 4'd7, 4'd8, 4'd9);
    push4(4'd6, 4'd7, 4'd8, 4'd9);
    step(); load = 1'b0;
    total++;
    if ({out_valid, out_data} !== {1'b1, 4'd6}) begin
      bad++; $display("FAIL held_recap: valid=%0b data=%0d want 1 6", out_valid, out_data);
    end
    repeat (5) step();
    total++;
    if (q4.size() != 0) begin
      bad++; $display("FAIL held_drain: %0d beats left want 0", q4.size());
    end
  endtask

  task automatic test_reset_mid();
    drive4(4'd4, 4'd3, 4'd2, 4'd1); load = 1'b1; ready = 1'b1;
    q4.push_back({4'd4, 2'd0, 1'b0});
    q4.push_back({4'd3, 2'd1, 1'b0});
    step(); load = 1'b0;
    step(); step();
    total++;
    if ({out_index, order_err} !== 3'b101) begin
      bad++; $display("FAIL pre_abort: idx=%0d err=%0b want 2 1", out_index, order_err);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data, out_index, out_last, busy, done, order_err} !== 11'd0) begin
      bad++; $display("FAIL abort: outputs=%b want all zero",
                      {out_valid, out_data, out_index, out_last, busy, done, order_err});
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({done, busy, out_valid} !== 3'b000) begin
        bad++; $display("FAIL no_resume: done/busy/valid=%b want 000", {done, busy, out_valid});
      end
    end
    drive4(4'd15, 4'd15, 4'd15, 4'd15); load = 1'b1;
    push4(4'd15, 4'd15, 4'd15, 4'd15);
    step(); load = 1'b0;
    repeat (4) step();
    total++;
    if ({done, order_err} !== 2'b10) begin
      bad++; $display("FAIL after_abort: done/err=%b want 10", {done, order_err});
    end
    step();
    total++;
    if (q4.size() != 0) begin
      bad++; $display("FAIL abort_drain: %0d beats left want 0", q4.size());
    end
  endtask

  task automatic test_wide();
    logic [7:0] v [4];
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        v[0] = 8'd0; v[1] = 8'd127; v[2] = 8'd128; v[3] = 8'd255;
      end else begin
        v[0] = 8'd0; v[1] = 8'd128; v[2] = 8'd127; v[3] = 8'd255;
      end
      w0 = v[0]; w1 = v[1]; w2 = v[2]; w3 = v[3]; load_w = 1'b1; ready_w = 1'b1;
      for (int i = 0; i < 4; i++) q8.push_back({v[i], 2'(i), (i == 3)});
      step(); load_w = 1'b0;
      total++;
      if (order_err_w !== (pass == 1)) begin
        bad++; $display("FAIL wide_err%0d: order_err=%0b want %0b", pass, order_err_w, pass == 1);
      end
      repeat (5) step();
      total++;
      if (q8.size() != 0 || busy_w !== 1'b0) begin
        bad++; $display("FAIL wide_drain%0d: left=%0d busy=%0b want 0 0", pass, q8.size(), busy_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_order();
    test_load_held();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
